mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DW, default 64, data/address width.
REQ-002 Parameter RW, default 5, register-index width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid, in_branch, in_memread, in_memwrite, in_memtoreg, in_regwrite, in_zero  in  1 each  EX/MEM register outputs.
REQ-006 in_pcsum, in_alu, in_wdata  in  DW each  branch target, ALU result/address, store data.
REQ-007 in_rd  in  RW  destination register.
REQ-008 stall  out  1  hold EX/MEM and upstream stages this cycle.
REQ-009 pcsrc  out  1  take branch; br_target  out  DW  equals in_pcsum; flush  out  1  flush IF/ID and ID/EX.
REQ-010 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  DW; dmem_ack  in  1; dmem_rdata  in  DW  data-memory handshake.
REQ-011 wb_regwrite, wb_memtoreg  out  1; wb_rd  out  RW; wb_rdata, wb_alu  out  DW  MEM/WB register.

Function
REQ-012 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-013 IDLE, in_valid with neither memread nor memwrite: MEM/WB loads inputs at next edge (latency 1), stall=0.
REQ-014 IDLE, in_valid with memread or memwrite: stall=1 combinationally; address, wdata and dmem_we=memwrite are registered; next state ACCESS; MEM/WB loads a bubble.
REQ-015 ACCESS: dmem_req=1 registered, address/data/we stable, stall=1; on dmem_ack=1 capture dmem_rdata, next state RESP; otherwise remain, no timeout.
REQ-016 RESP: stall=0; MEM/WB loads the held op with captured read data (zero for stores); next state IDLE.
REQ-017 Load latency = 2 cycles + ack wait; zero-wait ack gives wb update 3 edges after acceptance.
REQ-018 Bubble: wb_regwrite=0, wb_memtoreg=0, wb_rd=0, data outputs unchanged.
REQ-019 memread and memwrite both set: treated as store, no read data captured.
REQ-020 dmem_ack outside ACCESS is ignored.
REQ-021 pcsrc = in_valid & in_branch & in_zero, combinational; flush=pcsrc; evaluated only when stall=0.
REQ-022 in_valid=0: MEM/WB loads a bubble, FSM unchanged.

Reset
REQ-023 reset asserted: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all wb_* =0, misalign_err=0, immediately.
REQ-024 Reset during ACCESS aborts the access; a later dmem_ack is ignored.

Configuration
REQ-025 Macro MEM_MISALIGN_CHECK_EN defined: memory op with in_alu[2:0]!=0 issues no request, loads a bubble, sets sticky output misalign_err (1 bit) until reset.
REQ-026 Macro absent: no alignment check, misalign_err port absent, all addresses issued unchanged.

Structure
REQ-027 Shared package holds FSM state enum, DW/RW defaults, bubble constant.
REQ-028 One sub-module mem_wb_reg (MEM/WB register with load/bubble select); FSM and handshake stay in mem_stage.

Verification
REQ-029 ALU op, in_alu=0x10, in_rd=3, regwrite=1 -> next edge wb_alu=0x10, wb_rd=3, wb_regwrite=1, stall=0.
REQ-030 Load addr 0x40, ack after 2 ACCESS cycles, rdata=0xDEAD -> stall high 3 cycles, then wb_rdata=0xDEAD, wb_memtoreg=1.
REQ-031 Store addr 0x48, data 0x55, zero-wait ack -> dmem_we=1 one cycle, then wb_regwrite=0.
REQ-032 Branch=1, zero=1, pcsum=0x200 -> pcsrc=1, flush=1, br_target=0x200 same cycle; zero=0 -> pcsrc=0.
REQ-033 Reset in ACCESS, then stray ack -> state IDLE, dmem_req=0, wb unchanged at 0.
REQ-034 With MEM_MISALIGN_CHECK_EN, load addr 0x43 -> no dmem_req, misalign_err=1 sticky, wb_regwrite=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the MEM pipeline stage.
//   DW_DEF / RW_DEF : default data/address and register-index widths
//   state_e         : MEM-stage access FSM states
//   wb_ctrl_t       : MEM/WB control bits, with the bubble value
package mem_stage_pkg;

    localparam int DW_DEF = 64;
    localparam int RW_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    // A bubble writes nothing back.
    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory request/acknowledge bus.
//   req, we, addr, wdata : request side, driven by the MEM stage (master)
//   ack, rdata           : response side, driven by the memory (slave)
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg -- MEM/WB pipeline register.
//   clk, reset        : clock, asynchronous active-high reset
//   load              : 1 = capture the *_in values, 0 = insert a bubble
//   ctrl_in, rd_in    : write-back control and destination register
//   rdata_in, alu_in  : memory read data and ALU result
//   wb_*              : registered outputs
// A bubble clears control and rd but leaves the data outputs untouched.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  wb_ctrl_t      ctrl_in,
    input  logic [RW-1:0] rd_in,
    input  logic [DW-1:0] rdata_in,
    input  logic [DW-1:0] alu_in,
    output logic          wb_regwrite,
    output logic          wb_memtoreg,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_rdata,
    output logic [DW-1:0] wb_alu
);
    wb_ctrl_t      ctrl_q, ctrl_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] alu_q, alu_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        ctrl_d  = WB_CTRL_BUBBLE;
        rd_d    = '0;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        if (load) begin
            ctrl_d  = ctrl_in;
            rd_d    = rd_in;
            rdata_d = rdata_in;
            alu_d   = alu_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of process order.
        if (reset) begin
            ctrl_q  <= WB_CTRL_BUBBLE;
            rd_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
        end
    end

    assign wb_regwrite = ctrl_q.regwrite;
    assign wb_memtoreg = ctrl_q.memtoreg;
    assign wb_rd       = rd_q;
    assign wb_rdata    = rdata_q;
    assign wb_alu      = alu_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: data-memory handshake FSM, branch
// resolution and the MEM/WB register.
//   clk, reset              : clock, asynchronous active-high reset
//   in_*                    : EX/MEM register outputs
//   stall                   : hold EX/MEM and upstream stages this cycle
//   pcsrc, br_target, flush : branch decision, target, IF/ID+ID/EX flush
//   dmem (master)           : data-memory request/ack bus
//   wb_*                    : MEM/WB register outputs
//   misalign_err            : sticky misaligned-access flag (only when
//                             MEM_MISALIGN_CHECK_EN is defined)
// Optional feature macro: MEM_MISALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_branch,
    input  logic          in_memread,
    input  logic          in_memwrite,
    input  logic          in_memtoreg,
    input  logic          in_regwrite,
    input  logic          in_zero,
    input  logic [DW-1:0] in_pcsum,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_wdata,
    input  logic [RW-1:0] in_rd,
    output logic          stall,
    output logic          pcsrc,
    output logic [DW-1:0] br_target,
    output logic          flush,
    mem_stage_if.master   dmem,
    output logic          wb_regwrite,
    output logic          wb_memtoreg,
    output logic [RW-1:0] wb_rd,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic          misalign_err,
`endif
    output logic [DW-1:0] wb_rdata,
    output logic [DW-1:0] wb_alu
);
    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          is_load_q, is_load_d;
    wb_ctrl_t      ctrl_q, ctrl_d;
    logic [RW-1:0] rd_q, rd_d;

    logic          mem_op, misaligned, accept;
    logic          wb_load;
    wb_ctrl_t      wb_ctrl_in;
    logic [RW-1:0] wb_rd_in;
    logic [DW-1:0] wb_rdata_in, wb_alu_in;

    assign mem_op = in_valid & (in_memread | in_memwrite);

`ifdef MEM_MISALIGN_CHECK_EN
    logic err_q, err_d;
    assign misaligned = mem_op & (in_alu[2:0] != 3'b000);
    assign err_d      = err_q | ((state_q == IDLE) & misaligned);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign misalign_err = err_q;
`else
    assign misaligned = 1'b0;
`endif

    // A memory op is only taken from IDLE; a misaligned one is dropped.
    assign accept = (state_q == IDLE) & mem_op & ~misaligned;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; ack only matters while a request is outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = ACCESS;
            ACCESS:  if (dmem.ack) state_d = RESP;
            RESP:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Held access: captured at acceptance, stable throughout ACCESS.
    always_comb begin
        req_d     = (state_d == ACCESS);
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        is_load_d = is_load_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        if (accept) begin
            we_d      = in_memwrite;
            addr_d    = in_alu;
            wdata_d   = in_wdata;
            // memread+memwrite together behaves as a plain store.
            is_load_d = in_memread & ~in_memwrite;
            ctrl_d    = '{regwrite: in_regwrite, memtoreg: in_memtoreg};
            rd_d      = in_rd;
        end
        if ((state_q == ACCESS) && dmem.ack) begin
            rdata_d = is_load_q ? dmem.rdata : '0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            is_load_q <= 1'b0;
            ctrl_q    <= WB_CTRL_BUBBLE;
            rd_q      <= '0;
        end else begin
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            is_load_q <= is_load_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
        end
    end

    // Output logic: stall and MEM/WB source select.
    always_comb begin
        stall       = 1'b0;
        wb_load     = 1'b0;
        wb_ctrl_in  = '{regwrite: in_regwrite, memtoreg: in_memtoreg};
        wb_rd_in    = in_rd;
        wb_rdata_in = '0;
        wb_alu_in   = in_alu;
        case (state_q)
            IDLE: begin
                stall   = accept;
                wb_load = in_valid & ~mem_op;
            end
            ACCESS: stall = 1'b1;
            RESP: begin
                wb_load     = 1'b1;
                wb_ctrl_in  = ctrl_q;
                wb_rd_in    = rd_q;
                wb_rdata_in = rdata_q;
                wb_alu_in   = addr_q;
            end
            default: ;
        endcase
    end

    // While stalled, EX/MEM holds a memory op, so a branch is never taken then.
    assign pcsrc     = in_valid & in_branch & in_zero & ~stall;
    assign flush     = pcsrc;
    assign br_target = in_pcsum;

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    mem_wb_reg #(.DW(DW), .RW(RW)) u_mem_wb_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (wb_load),
        .ctrl_in     (wb_ctrl_in),
        .rd_in       (wb_rd_in),
        .rdata_in    (wb_rdata_in),
        .alu_in      (wb_alu_in),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .wb_rd       (wb_rd),
        .wb_rdata    (wb_rdata),
        .wb_alu      (wb_alu)
    );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage: a vector table for
// single-cycle ops, then hand-written load/store/reset sequences.
// Build with MEM_MISALIGN_CHECK_EN defined to also cover the alignment check.
module tb_mem_stage;
    localparam int DW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid, in_branch, in_memread, in_memwrite;
    logic          in_memtoreg, in_regwrite, in_zero;
    logic [DW-1:0] in_pcsum, in_alu, in_wdata;
    logic [RW-1:0] in_rd;
    logic          stall, pcsrc, flush;
    logic [DW-1:0] br_target;
    logic          wb_regwrite, wb_memtoreg;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_rdata, wb_alu;
`ifdef MEM_MISALIGN_CHECK_EN
    logic          misalign_err;
`endif

    mem_stage_if #(.DW(DW)) dmem_bus ();

    mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_branch   (in_branch),
        .in_memread  (in_memread),
        .in_memwrite (in_memwrite),
        .in_memtoreg (in_memtoreg),
        .in_regwrite (in_regwrite),
        .in_zero     (in_zero),
        .in_pcsum    (in_pcsum),
        .in_alu      (in_alu),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .stall       (stall),
        .pcsrc       (pcsrc),
        .br_target   (br_target),
        .flush       (flush),
        .dmem        (dmem_bus),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .wb_rd       (wb_rd),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .wb_rdata    (wb_rdata),
        .wb_alu      (wb_alu)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_branch = 0; in_memread = 0; in_memwrite = 0;
        in_memtoreg = 0; in_regwrite = 0; in_zero = 0;
        in_pcsum = '0; in_alu = '0; in_wdata = '0; in_rd = '0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    endtask

    typedef struct {
        string       name;
        logic        valid, branch, zero, regwrite, memtoreg;
        logic [63:0] pcsum, alu;
        logic [4:0]  rd;
        logic        exp_pcsrc, exp_regwrite, exp_memtoreg;
        logic [4:0]  exp_rd;
        logic [63:0] exp_alu;
    } vec_t;

    vec_t vecs[5];
    int   stall_cnt, we_cnt;

    initial begin
        vecs[0] = '{name:"alu_r3", valid:1, branch:0, zero:0, regwrite:1, memtoreg:0,
                    pcsum:64'h0, alu:64'h10, rd:5'd3,
                    exp_pcsrc:0, exp_regwrite:1, exp_memtoreg:0, exp_rd:5'd3, exp_alu:64'h10};
        vecs[1] = '{name:"br_taken", valid:1, branch:1, zero:1, regwrite:0, memtoreg:0,
                    pcsum:64'h200, alu:64'h77, rd:5'd0,
                    exp_pcsrc:1, exp_regwrite:0, exp_memtoreg:0, exp_rd:5'd0, exp_alu:64'h77};
        vecs[2] = '{name:"br_not_taken", valid:1, branch:1, zero:0, regwrite:1, memtoreg:0,
                    pcsum:64'h200, alu:64'h88, rd:5'd2,
                    exp_pcsrc:0, exp_regwrite:1, exp_memtoreg:0, exp_rd:5'd2, exp_alu:64'h88};
        vecs[3] = '{name:"invalid_bubble", valid:0, branch:1, zero:1, regwrite:1, memtoreg:1,
                    pcsum:64'h300, alu:64'h99, rd:5'd7,
                    exp_pcsrc:0, exp_regwrite:0, exp_memtoreg:0, exp_rd:5'd0, exp_alu:64'h88};
        vecs[4] = '{name:"alu_max", valid:1, branch:0, zero:1, regwrite:1, memtoreg:1,
                    pcsum:64'h0, alu:64'hFFFF_FFFF_FFFF_FFFF, rd:5'd31,
                    exp_pcsrc:0, exp_regwrite:1, exp_memtoreg:1, exp_rd:5'd31,
                    exp_alu:64'hFFFF_FFFF_FFFF_FFFF};

        // ---- reset state, checked before any clock edge ----
        clear_inputs();
        #1 reset = 1'b1;
        #1;
        check("rst_req", dmem_bus.req, 0);
        check("rst_we", dmem_bus.we, 0);
        check("rst_addr", dmem_bus.addr, 0);
        check("rst_wdata", dmem_bus.wdata, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_wb_memtoreg", wb_memtoreg, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_rdata", wb_rdata, 0);
        check("rst_wb_alu", wb_alu, 0);
        check("rst_stall", stall, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        check("rst_misalign_err", misalign_err, 0);
`endif
        tick();
        reset = 1'b0;

        // ---- single-cycle table ----
        for (int i = 0; i < 5; i++) begin
            in_valid = vecs[i].valid; in_branch = vecs[i].branch; in_zero = vecs[i].zero;
            in_regwrite = vecs[i].regwrite; in_memtoreg = vecs[i].memtoreg;
            in_memread = 0; in_memwrite = 0;
            in_pcsum = vecs[i].pcsum; in_alu = vecs[i].alu; in_rd = vecs[i].rd;
            #1;
            check({vecs[i].name, "_stall"}, stall, 0);
            check({vecs[i].name, "_pcsrc"}, pcsrc, vecs[i].exp_pcsrc);
            check({vecs[i].name, "_flush"}, flush, vecs[i].exp_pcsrc);
            check({vecs[i].name, "_br_target"}, br_target, vecs[i].pcsum);
            tick();
            check({vecs[i].name, "_wb_regwrite"}, wb_regwrite, vecs[i].exp_regwrite);
            check({vecs[i].name, "_wb_memtoreg"}, wb_memtoreg, vecs[i].exp_memtoreg);
            check({vecs[i].name, "_wb_rd"}, wb_rd, vecs[i].exp_rd);
            check({vecs[i].name, "_wb_alu"}, wb_alu, vecs[i].exp_alu);
        end

        // ---- stray ack in IDLE is ignored: next ALU op still has latency 1 ----
        clear_inputs();
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'h1111;
        tick();
        check("idle_ack_req", dmem_bus.req, 0);
        in_valid = 1; in_regwrite = 1; in_rd = 5'd4; in_alu = 64'h20;
        #1 check("idle_ack_stall", stall, 0);
        tick();
        check("idle_ack_wb_rd", wb_rd, 4);
        check("idle_ack_wb_alu", wb_alu, 64'h20);
        check("idle_ack_wb_regwrite", wb_regwrite, 1);

        // ---- load 0x40, ack in second ACCESS cycle ----
        clear_inputs();
        in_valid = 1; in_memread = 1; in_memtoreg = 1; in_regwrite = 1;
        in_rd = 5'd5; in_alu = 64'h40; in_branch = 1; in_zero = 1;
        stall_cnt = 0;
        #1;
        check("ld_stall_idle", stall, 1);
        check("ld_pcsrc_stalled", pcsrc, 0);
        stall_cnt += int'(stall);
        tick();
        check("ld_req_acc1", dmem_bus.req, 1);
        check("ld_addr", dmem_bus.addr, 64'h40);
        check("ld_we", dmem_bus.we, 0);
        check("ld_wb_bubble", wb_regwrite, 0);
        stall_cnt += int'(stall);
        tick();
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'hDEAD;
        #1;
        check("ld_req_acc2", dmem_bus.req, 1);
        stall_cnt += int'(stall);
        tick();
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        check("ld_req_resp", dmem_bus.req, 0);
        check("ld_stall_resp", stall, 0);
        check("ld_wb_still_bubble", wb_regwrite, 0);
        stall_cnt += int'(stall);
        tick();
        clear_inputs();
        check("ld_stall_cycles", stall_cnt, 3);
        check("ld_wb_rdata", wb_rdata, 64'hDEAD);
        check("ld_wb_memtoreg", wb_memtoreg, 1);
        check("ld_wb_regwrite", wb_regwrite, 1);
        check("ld_wb_rd", wb_rd, 5);
        check("ld_wb_alu", wb_alu, 64'h40);

        // ---- memread+memwrite: store semantics, no read data captured ----
        in_valid = 1; in_memread = 1; in_memwrite = 1; in_regwrite = 1; in_memtoreg = 1;
        in_rd = 5'd9; in_alu = 64'h50; in_wdata = 64'h66;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'hBEEF;
        tick();
        check("rw_we", dmem_bus.we, 1);
        tick();
        dmem_bus.ack = 1'b0;
        tick();
        clear_inputs();
        check("rw_wb_rdata_zero", wb_rdata, 0);
        check("rw_wb_rd", wb_rd, 9);
        check("rw_wb_alu", wb_alu, 64'h50);

        // ---- store 0x48 / 0x55, zero-wait ack ----
        in_valid = 1; in_memwrite = 1; in_alu = 64'h48; in_wdata = 64'h55;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'h7777;
        we_cnt = 0;
        #1;
        check("st_stall_idle", stall, 1);
        we_cnt += int'(dmem_bus.we);
        tick();
        check("st_req", dmem_bus.req, 1);
        check("st_addr", dmem_bus.addr, 64'h48);
        check("st_wdata", dmem_bus.wdata, 64'h55);
        we_cnt += int'(dmem_bus.we);
        tick();
        dmem_bus.ack = 1'b0;
        check("st_req_resp", dmem_bus.req, 0);
        we_cnt += int'(dmem_bus.we);
        tick();
        clear_inputs();
        check("st_we_cycles", we_cnt, 1);
        check("st_wb_regwrite", wb_regwrite, 0);
        check("st_wb_alu", wb_alu, 64'h48);

        // ---- reset during ACCESS, then a stray ack ----
        in_valid = 1; in_memread = 1; in_regwrite = 1; in_rd = 5'd6; in_alu = 64'h80;
        tick();
        check("ra_req_before", dmem_bus.req, 1);
        clear_inputs();
        #2 reset = 1'b1;
        #1;
        check("ra_req_async", dmem_bus.req, 0);
        check("ra_addr_async", dmem_bus.addr, 0);
        check("ra_wb_alu_async", wb_alu, 0);
        #2 reset = 1'b0;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'h1234;
        tick();
        tick();
        dmem_bus.ack = 1'b0;
        check("ra_req_after", dmem_bus.req, 0);
        check("ra_stall_after", stall, 0);
        check("ra_wb_regwrite", wb_regwrite, 0);
        check("ra_wb_rdata", wb_rdata, 0);
        check("ra_wb_alu", wb_alu, 0);
        in_valid = 1; in_regwrite = 1; in_rd = 5'd8; in_alu = 64'h30;
        tick();
        clear_inputs();
        check("ra_idle_wb_rd", wb_rd, 8);
        check("ra_idle_wb_alu", wb_alu, 64'h30);

`ifdef MEM_MISALIGN_CHECK_EN
        // ---- misaligned load is dropped and flagged ----
        in_valid = 1; in_memread = 1; in_regwrite = 1; in_memtoreg = 1;
        in_rd = 5'd2; in_alu = 64'h43;
        #1 check("mis_stall", stall, 0);
        tick();
        clear_inputs();
        check("mis_req", dmem_bus.req, 0);
        check("mis_err", misalign_err, 1);
        check("mis_wb_regwrite", wb_regwrite, 0);
        tick();
        check("mis_err_sticky", misalign_err, 1);
        check("mis_req_later", dmem_bus.req, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
